// File: rtl/tmnt_prio_mixer.sv
// tmnt_prio_mixer: two-stage layer priority mixer with vblank-latched mode register
module tmnt_prio_mixer (
    input  logic       V6M,
    input  logic       NRESET,
    input  logic [7:0] FIX_PX,
    input  logic [7:0] LA_PX,
    input  logic [7:0] LB_PX,
    input  logic [7:0] OBJ_PX,
    input  logic       OBJ_PRI,
    input  logic       OBJ_SH,
    input  logic       NHBLK,
    input  logic       NVBLK,
    input  logic       PRIO_CS,
    input  logic       NLWR,
    input  logic [7:0] CPU_DIN,
    output logic [9:0] CD,
    output logic       SHADOW,
    output logic       NCBLK
);
    logic [2:0] pend, act;
    logic       nvblk_d;
    logic [7:0] fix_q, la_q, lb_q, obj_q;
    logic       pri_q, sh_q, cblk_q;
    logic       fix_op, la_op, lb_op, obj_op;
    logic [7:0] f_px, k_px;
    logic [1:0] f_code, k_code;
    logic       f_op, fix_v, obj_v, shadow_sel;
    logic [9:0] sel;

    // CPU mode write and vblank-start transfer; ACT takes the pre-write PEND on a collision
    always_ff @(posedge V6M or negedge NRESET)
        if (!NRESET) begin
            pend    <= '0;
            act     <= '0;
            nvblk_d <= 1'b0;
        end else begin
            nvblk_d <= NVBLK;
            if (!PRIO_CS && !NLWR) pend <= CPU_DIN[2:0];
            if (nvblk_d && !NVBLK) act <= pend;
        end

    // Stage 1: register pixels, sprite attributes, raw blank and opaque flags
    always_ff @(posedge V6M or negedge NRESET)
        if (!NRESET) begin
            {fix_q, la_q, lb_q, obj_q} <= '0;
            {pri_q, sh_q, cblk_q}      <= '0;
            {fix_op, la_op, lb_op, obj_op} <= '0;
        end else begin
            fix_q  <= FIX_PX;
            la_q   <= LA_PX;
            lb_q   <= LB_PX;
            obj_q  <= OBJ_PX;
            pri_q  <= OBJ_PRI;
            sh_q   <= OBJ_SH;
            cblk_q <= NHBLK & NVBLK;
            fix_op <= |FIX_PX[3:0];
            la_op  <= |LA_PX[3:0];
            lb_op  <= |LB_PX[3:0];
            obj_op <= |OBJ_PX[3:0];
        end

    // Stage 2 priority: first opaque of FIX > OBJ > F > K (or FIX > F > OBJ > K), else K
    always_comb begin
        f_px       = act[0] ? lb_q : la_q;
        k_px       = act[0] ? la_q : lb_q;
        f_code     = act[0] ? 2'b10 : 2'b01;
        k_code     = act[0] ? 2'b01 : 2'b10;
        f_op       = act[0] ? lb_op : la_op;
        fix_v      = fix_op & ~act[1];
        obj_v      = obj_op & ~sh_q;
        sel        = fix_v          ? {2'b00, fix_q} :
                     !pri_q && obj_v ? {2'b11, obj_q} :
                     f_op           ? {f_code, f_px} :
                     obj_v          ? {2'b11, obj_q} :
                                      {k_code, k_px};
        shadow_sel = act[2] & sh_q & obj_op & (sel[9:8] != 2'b00);
    end

    // Stage 2 output register with blanking forcing CD and SHADOW low
    always_ff @(posedge V6M or negedge NRESET)
        if (!NRESET) begin
            CD     <= '0;
            SHADOW <= 1'b0;
            NCBLK  <= 1'b0;
        end else begin
            CD     <= cblk_q ? sel : 10'd0;
            SHADOW <= cblk_q & shadow_sel;
            NCBLK  <= cblk_q;
        end
endmodule

// File: tb/tb_tmnt_prio_mixer.sv
// tb_tmnt_prio_mixer: directed checks of priority, mode latching, shadow, blanking and reset
module tb_tmnt_prio_mixer;
    logic       V6M = 1'b0;
    logic       NRESET;
    logic [7:0] FIX_PX, LA_PX, LB_PX, OBJ_PX, CPU_DIN;
    logic       OBJ_PRI, OBJ_SH, NHBLK, NVBLK, PRIO_CS, NLWR;
    logic [9:0] CD;
    logic       SHADOW, NCBLK;
    int         checks = 0;
    int         errors = 0;

    tmnt_prio_mixer dut (
        .V6M(V6M), .NRESET(NRESET), .FIX_PX(FIX_PX), .LA_PX(LA_PX), .LB_PX(LB_PX),
        .OBJ_PX(OBJ_PX), .OBJ_PRI(OBJ_PRI), .OBJ_SH(OBJ_SH), .NHBLK(NHBLK), .NVBLK(NVBLK),
        .PRIO_CS(PRIO_CS), .NLWR(NLWR), .CPU_DIN(CPU_DIN), .CD(CD), .SHADOW(SHADOW), .NCBLK(NCBLK)
    );

    always #5 V6M = ~V6M;

    task automatic tick(input int n);
        repeat (n) @(posedge V6M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [7:0] v);
        PRIO_CS = 1'b0; NLWR = 1'b0; CPU_DIN = v;
        tick(1);
        PRIO_CS = 1'b1; NLWR = 1'b1; CPU_DIN = 8'hFF;
    endtask

    task automatic vbl_pulse();
        NVBLK = 1'b0;
        tick(1);
        NVBLK = 1'b1;
        tick(1);
    endtask

    task automatic pix(input logic [7:0] f, o, a, b, input logic p, s);
        FIX_PX = f; OBJ_PX = o; LA_PX = a; LB_PX = b; OBJ_PRI = p; OBJ_SH = s;
    endtask

    initial begin
        NRESET = 1'b0; NHBLK = 1'b1; NVBLK = 1'b1; PRIO_CS = 1'b1; NLWR = 1'b1; CPU_DIN = 8'h00;
        pix(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        chk("rst_cd", CD, 10'h000);
        chk("rst_shadow", {9'd0, SHADOW}, 10'd0);
        chk("rst_ncblk", {9'd0, NCBLK}, 10'd0);
        tick(1);
        NRESET = 1'b1;

        pix(8'h00, 8'h35, 8'h12, 8'h47, 1'b0, 1'b0);
        tick(2);
        chk("prio_obj_front", CD, 10'h335);
        chk("prio_ncblk", {9'd0, NCBLK}, 10'd1);
        OBJ_PRI = 1'b1;
        tick(2);
        chk("prio_obj_behind", CD, 10'h112);

        pix(8'h00, 8'h00, 8'h12, 8'h47, 1'b0, 1'b0);
        cpu_wr(8'h01);
        tick(2);
        chk("swap_before_vbl", CD, 10'h112);
        vbl_pulse();
        tick(2);
        chk("swap_after_vbl", CD, 10'h247);

        cpu_wr(8'h02);
        vbl_pulse();
        pix(8'h81, 8'h00, 8'h12, 8'h47, 1'b0, 1'b0);
        tick(2);
        chk("fixoff_on", CD, 10'h112);
        cpu_wr(8'h00);
        vbl_pulse();
        tick(2);
        chk("fixoff_off", CD, 10'h081);

        cpu_wr(8'h04);
        vbl_pulse();
        pix(8'h00, 8'h3F, 8'h12, 8'h47, 1'b0, 1'b1);
        tick(2);
        chk("shadow_cd", CD, 10'h112);
        chk("shadow_on", {9'd0, SHADOW}, 10'd1);
        FIX_PX = 8'h81;
        tick(2);
        chk("shadow_fix_cd", CD, 10'h081);
        chk("shadow_fix_off", {9'd0, SHADOW}, 10'd0);

        NHBLK = 1'b0;
        tick(2);
        chk("hblk_cd", CD, 10'h000);
        chk("hblk_ncblk", {9'd0, NCBLK}, 10'd0);
        chk("hblk_shadow", {9'd0, SHADOW}, 10'd0);
        NHBLK = 1'b1;
        pix(8'h00, 8'h00, 8'h00, 8'h40, 1'b0, 1'b0);
        tick(1);
        chk("latency_1edge", {9'd0, NCBLK}, 10'd0);
        tick(1);
        chk("alltrans_cd", CD, 10'h240);
        chk("alltrans_ncblk", {9'd0, NCBLK}, 10'd1);

        cpu_wr(8'h00);
        vbl_pulse();
        pix(8'h81, 8'h00, 8'h12, 8'h47, 1'b0, 1'b0);
        NVBLK = 1'b0; PRIO_CS = 1'b0; NLWR = 1'b0; CPU_DIN = 8'h07;
        tick(1);
        NVBLK = 1'b1; PRIO_CS = 1'b1; NLWR = 1'b1;
        tick(2);
        chk("collide_act_old", CD, 10'h081);
        vbl_pulse();
        tick(2);
        chk("collide_act_new", CD, 10'h247);

        #3;
        NRESET = 1'b0;
        #1;
        chk("midrst_cd", CD, 10'h000);
        chk("midrst_ncblk", {9'd0, NCBLK}, 10'd0);
        PRIO_CS = 1'b0; NLWR = 1'b0; CPU_DIN = 8'h07;
        tick(2);
        PRIO_CS = 1'b1; NLWR = 1'b1;
        NRESET = 1'b1;
        vbl_pulse();
        tick(2);
        chk("rst_write_ignored", CD, 10'h081);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
